// File: rtl/or1200_if_pkg.sv
// Shared definitions for the OR1200 instruction-fetch prefetch queue.
// Holds the two NOP encodings, the instruction-tag error codes, the queue
// entry layout and a helper that packs a fetch response into an entry.
package or1200_if_pkg;

  // NOP injected on flush, forced no-delay-slot, rfe and fetch errors
  localparam logic [31:0] NOP_EXC  = 32'h1541_0000;
  // NOP presented while no instruction is available
  localparam logic [31:0] NOP_IDLE = 32'h1561_0000;

  localparam logic [3:0] ITAG_TE = 4'hd;  // ITLB miss
  localparam logic [3:0] ITAG_PE = 4'hc;  // IMMU page fault
  localparam logic [3:0] ITAG_BE = 4'hb;  // bus error

  // err[2]=TLB miss, err[1]=MMU fault, err[0]=bus error
  typedef struct packed {
    logic [31:0] insn;
    logic [29:0] pc;
    logic [2:0]  err;
  } if_entry_t;

  // Build an entry from one fetch response; errored fetches carry a NOP
  function automatic if_entry_t make_entry(input logic [31:0] dat,
                                           input logic [29:0] pc,
                                           input logic        err,
                                           input logic [3:0]  tag);
    if_entry_t e;
    e.insn = err ? NOP_EXC : dat;
    e.pc   = pc;
    e.err  = {err && (tag == ITAG_TE),
              err && (tag == ITAG_PE),
              err && (tag == ITAG_BE)};
    return e;
  endfunction

endpackage

// File: rtl/or1200_if_pfq_mem.sv
// Prefetch queue storage: DEPTH entries, one write port, one asynchronous
// read port. Contents are not reset; validity is tracked by the pointers.
//   clk      : rising-edge clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : entry to store
//   raddr_i  : read address
//   rdata_o  : entry at raddr_i (combinational)
module or1200_if_pfq_mem
  import or1200_if_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  if_entry_t       wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output if_entry_t       rdata_o
);

  if_entry_t mem_q [DEPTH];

  // Entry write
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/or1200_if_pfq.sv
// OR1200 instruction-fetch prefetch queue. Buffers fetch responses and
// presents the head instruction, its PC and its exception flags to ID.
// When the queue is empty and ID consumes in the same cycle as a response,
// the response falls straight through with zero latency.
//   clk, rst         : clock, synchronous active-low reset
//   icpu_*_i         : fetch response (data, ack, err, address, error tag)
//   icpu_rdy_o       : queue can accept a response (not full)
//   if_freeze        : ID not consuming
//   if_flushpipe     : drop all queued and in-flight instructions
//   no_more_dslot    : force NOP and suppress exceptions
//   rfe              : force NOP
//   if_insn, if_pc   : instruction and PC presented to ID
//   if_stall         : no instruction available
//   except_*         : exception flags of the head entry
//   if_fill          : occupancy
module or1200_if_pfq
  import or1200_if_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     icpu_dat_i,
  input  logic            icpu_ack_i,
  input  logic            icpu_err_i,
  input  logic [31:0]     icpu_adr_i,
  input  logic [3:0]      icpu_tag_i,
  output logic            icpu_rdy_o,
  input  logic            if_freeze,
  input  logic            if_flushpipe,
  input  logic            no_more_dslot,
  input  logic            rfe,
  output logic [31:0]     if_insn,
  output logic [31:0]     if_pc,
  output logic            if_stall,
  output logic            except_itlbmiss,
  output logic            except_immufault,
  output logic            except_ibuserr,
  output logic [CNTW-1:0] if_fill
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] fill_q, fill_d;

  logic      resp_s, full_s, empty_s, accept_s, consume_s;
  logic      wr_en_s, pop_s, head_vld_s;
  if_entry_t new_entry_s, rd_entry_s, head_s;
  logic      unused_adr_s;

  // Wrapping pointer increment
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign unused_adr_s = ^icpu_adr_i[1:0];

  assign resp_s    = icpu_ack_i | icpu_err_i;
  assign full_s    = (fill_q == CNTW'(DEPTH));
  assign empty_s   = (fill_q == CNTW'(0));
  assign accept_s  = resp_s & ~full_s & ~if_flushpipe;
  assign if_stall  = empty_s & ~resp_s;
  assign consume_s = ~if_freeze & ~if_stall & ~if_flushpipe;

  // Fall-through (empty and consumed now) bypasses storage entirely
  assign wr_en_s = accept_s & ~(empty_s & consume_s);
  assign pop_s   = consume_s & ~empty_s;

  assign new_entry_s = make_entry(icpu_dat_i, icpu_adr_i[31:2], icpu_err_i, icpu_tag_i);

  or1200_if_pfq_mem #(.DEPTH(DEPTH), .AW(PW)) u_mem (
    .clk     (clk),
    .we_i    (wr_en_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (new_entry_s),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry_s)
  );

  // Pointer and occupancy next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (if_flushpipe) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_en_s, pop_s})
        2'b10:   fill_d = fill_q + CNTW'(1);
        2'b01:   fill_d = fill_q - CNTW'(1);
        default: fill_d = fill_q;
      endcase
    end
  end

  // Pointer and occupancy state; reset wins over everything
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Head selection and output muxing toward ID
  always_comb begin
    head_s     = empty_s ? new_entry_s : rd_entry_s;
    head_vld_s = ~empty_s | resp_s;
    if (no_more_dslot | rfe | if_flushpipe) begin
      if_insn = NOP_EXC;
    end else if (head_vld_s) begin
      if_insn = head_s.insn;
    end else begin
      if_insn = NOP_IDLE;
    end
    if_pc = {head_s.pc, 2'b00};
    if (head_vld_s && !no_more_dslot) begin
      {except_itlbmiss, except_immufault, except_ibuserr} = head_s.err;
    end else begin
      {except_itlbmiss, except_immufault, except_ibuserr} = 3'b000;
    end
  end

  assign icpu_rdy_o = ~full_s;
  assign if_fill    = fill_q;

endmodule

// File: doc/or1200_if_pfq.md
OR1200_IF_PFQ -- requirements
Module: or1200_if_pfq

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning prefetch queue entries; legal values are 2, 4 and 8.
REQ-002 SHALL have parameter CNTW, default $clog2(DEPTH)+1, meaning occupancy counter width.
REQ-003 SHALL have one clock and a synchronous, active-low reset, with ports `clk` (clock) and `rst` (reset).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  reset; synchronous, active-low.
REQ-006 icpu_dat_i  in  32  fetched instruction.
REQ-007 icpu_ack_i  in  1  fetch completed OK.
REQ-008 icpu_err_i  in  1  fetch completed with error.
REQ-009 icpu_adr_i  in  32  address of the current fetch.
REQ-010 icpu_tag_i  in  4  error tag (TE=4'hd, PE=4'hc, BE=4'hb).
REQ-011 icpu_rdy_o  out  1  queue can accept a response; equals !full.
REQ-012 if_freeze  in  1  ID stage not consuming.
REQ-013 if_flushpipe  in  1  discard all queued and in-flight instructions.
REQ-014 no_more_dslot  in  1  force NOP and suppress exceptions.
REQ-015 rfe  in  1  force NOP.
REQ-016 if_insn  out  32  instruction presented to ID.
REQ-017 if_pc  out  32  PC of if_insn, with bits [1:0] = 0.
REQ-018 if_stall  out  1  no instruction available.
REQ-019 except_itlbmiss, except_immufault, except_ibuserr  out  1 each  exception flags of the head entry.
REQ-020 if_fill  out  CNTW  current occupancy.

Function
REQ-021 Entry = {insn[31:0], pc[31:2], err[2:0]}; err bits are TE/PE/BE matches of icpu_tag_i gated by icpu_err_i; insn = 32'h1541_0000 when icpu_err_i is set.
REQ-022 Response = icpu_ack_i|icpu_err_i; accept = response & !full & !if_flushpipe; consume = !if_freeze & !if_stall & !if_flushpipe.
REQ-023 Empty, response and consume in the same cycle: fall-through; head taken combinationally from the icpu_* inputs, nothing written, zero latency.
REQ-024 Otherwise, accept writes the entry at the write pointer; it is visible as head one cycle later if the queue was empty.
REQ-025 Not empty and consume: advance the read pointer.
REQ-026 Accept and consume in the same cycle: if_fill unchanged.
REQ-027 Full: a response is dropped; if_fill stays DEPTH; icpu_rdy_o=0 beforehand, and the IC shall not respond while icpu_rdy_o=0.
REQ-028 Pointers wrap modulo DEPTH; if_fill ranges 0..DEPTH with no over- or underflow.
REQ-029 if_flushpipe: pointers and if_fill clear at the next edge; a same-cycle response is discarded; if_insn=32'h1541_0000 during the flush cycle.
REQ-030 if_insn priority: no_more_dslot|rfe|if_flushpipe -> 32'h1541_0000; else head valid -> head insn; else 32'h1561_0000.
REQ-031 if_stall = empty & !response.
REQ-032 if_pc = head pc; when empty, if_pc = {icpu_adr_i[31:2],2'b00}.
REQ-033 Exception outputs = head err bits, forced to 0 when no_more_dslot=1 or the head is invalid.

Reset
REQ-034 rst=0 at a clock edge clears pointers and if_fill; resulting outputs: icpu_rdy_o=1, if_stall=1 (absent a response), if_insn=32'h1561_0000, exception outputs 0.
REQ-035 Reset mid-operation discards all entries; storage contents need not be cleared.
REQ-036 Reset overrides flush, accept and consume.

Structure
REQ-037 Package or1200_if_pkg holds the NOP constants 32'h1541_0000 and 32'h1561_0000, the ITAG TE/PE/BE codes, and the typedef if_entry_t.
REQ-038 Storage is one sub-module, or1200_if_pfq_mem: DEPTH x if_entry_t, with 1 write port and 1 asynchronous read port.
REQ-039 Pointer, count and output muxing live in or1200_if_pfq.

Verification
REQ-040 Empty, if_freeze=0, ack with dat=32'hA5A5_0001, adr=32'h100 -> same cycle if_insn=32'hA5A5_0001, if_pc=32'h100, if_fill=0.
REQ-041 if_freeze=1, 4 acks (DEPTH=4) -> if_fill=4, icpu_rdy_o=0; release freeze -> 4 instructions drained in order, then if_stall=1.
REQ-042 err with tag 4'hc queued behind 2 OK entries -> except_immufault=1 on the 3rd consume with if_insn=32'h1541_0000; forced to 0 if no_more_dslot=1.
REQ-043 if_fill=3 plus a same-cycle ack and if_flushpipe=1 -> if_insn=32'h1541_0000 that cycle; next cycle if_fill=0, if_stall=1.
REQ-044 rst=0 while if_fill=2 -> next cycle if_fill=0, icpu_rdy_o=1; asserting rst without a clock edge changes nothing.
REQ-045 Random accept/consume with wrap over 100 cycles, DEPTH in {2,8} -> order preserved and if_fill matches the scoreboard.
